// File: rtl/win5x5_if.sv
// Pixel-in / window-out bundle for the 5x5 window generator.
// With WIN_SOF_EN defined, a frame-start marker (sof) is added.
interface win5x5_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_pix;
`ifdef WIN_SOF_EN
  logic              sof;
`endif
  logic [DATA_W-1:0] x_0,  x_1,  x_2,  x_3,  x_4;
  logic [DATA_W-1:0] x_5,  x_6,  x_7,  x_8,  x_9;
  logic [DATA_W-1:0] x_10, x_11, x_12, x_13, x_14;
  logic [DATA_W-1:0] x_15, x_16, x_17, x_18, x_19;
  logic [DATA_W-1:0] x_20, x_21, x_22, x_23, x_24;
  logic              win_valid;
  logic              eof;

  modport master (
`ifdef WIN_SOF_EN
    output sof,
`endif
    output in_valid, in_pix,
    input  x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9,
    input  x_10, x_11, x_12, x_13, x_14, x_15, x_16, x_17, x_18, x_19,
    input  x_20, x_21, x_22, x_23, x_24, win_valid, eof
  );

  modport slave (
`ifdef WIN_SOF_EN
    input  sof,
`endif
    input  in_valid, in_pix,
    output x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7, x_8, x_9,
    output x_10, x_11, x_12, x_13, x_14, x_15, x_16, x_17, x_18, x_19,
    output x_20, x_21, x_22, x_23, x_24, win_valid, eof
  );
endinterface

// File: rtl/win5x5_gen.sv
// Streaming 5x5 window generator: four line buffers feed a 5x5 tap array.
// Optional WIN_SOF_EN adds a sof input that restarts the frame counters.
module win5x5_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input logic     clk,
  input logic     rst,
  win5x5_if.slave bus
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]  col_q, col_d, col_eff;
  logic [ROW_W-1:0]  row_q, row_d, row_eff;
  logic [DATA_W-1:0] win_q [5][5];
  logic [DATA_W-1:0] win_d [5][5];
  logic              win_valid_q, win_valid_d;
  logic              eof_q, eof_d;
  logic [DATA_W-1:0] lb_q  [4][IMG_W];
  logic [DATA_W-1:0] lb_rd [4];
  logic              accept, restart, last_col, last_row;

  assign accept = bus.in_valid;
`ifdef WIN_SOF_EN
  assign restart = bus.sof & bus.in_valid;
`else
  assign restart = 1'b0;
`endif

  // A sof-tagged pixel is treated as coordinate (0,0).
  assign col_eff  = restart ? '0 : col_q;
  assign row_eff  = restart ? '0 : row_q;
  assign last_col = (col_eff == COL_W'(IMG_W - 1));
  assign last_row = (row_eff == ROW_W'(IMG_H - 1));

  always_comb begin
    for (int k = 0; k < 4; k++) lb_rd[k] = lb_q[k][col_eff];
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    eof_d       = 1'b0;
    if (accept) begin
      // Column gate keeps a qualified window from straddling two lines.
      win_valid_d = (row_eff >= ROW_W'(4)) && (col_eff >= COL_W'(4));
      eof_d       = last_col && last_row;
      col_d       = last_col ? '0 : col_eff + COL_W'(1);
      if (last_col) row_d = last_row ? '0 : row_eff + ROW_W'(1);
      else          row_d = row_eff;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win_d[r][c] = win_q[r][c+1];
      end
      win_d[4][4] = bus.in_pix;
      for (int r = 0; r < 4; r++) win_d[r][4] = lb_rd[3-r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      win_valid_q <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      eof_q       <= eof_d;
    end
  end

  // Line buffer cascade, read-before-write at the current column.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb_q[0][col_eff] <= bus.in_pix;
      for (int k = 1; k < 4; k++) lb_q[k][col_eff] <= lb_rd[k-1];
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.eof       = eof_q;

  assign bus.x_0  = win_q[0][0]; assign bus.x_1  = win_q[0][1]; assign bus.x_2  = win_q[0][2];
  assign bus.x_3  = win_q[0][3]; assign bus.x_4  = win_q[0][4];
  assign bus.x_5  = win_q[1][0]; assign bus.x_6  = win_q[1][1]; assign bus.x_7  = win_q[1][2];
  assign bus.x_8  = win_q[1][3]; assign bus.x_9  = win_q[1][4];
  assign bus.x_10 = win_q[2][0]; assign bus.x_11 = win_q[2][1]; assign bus.x_12 = win_q[2][2];
  assign bus.x_13 = win_q[2][3]; assign bus.x_14 = win_q[2][4];
  assign bus.x_15 = win_q[3][0]; assign bus.x_16 = win_q[3][1]; assign bus.x_17 = win_q[3][2];
  assign bus.x_18 = win_q[3][3]; assign bus.x_19 = win_q[3][4];
  assign bus.x_20 = win_q[4][0]; assign bus.x_21 = win_q[4][1]; assign bus.x_22 = win_q[4][2];
  assign bus.x_23 = win_q[4][3]; assign bus.x_24 = win_q[4][4];
endmodule

// File: tb/tb_win5x5_gen.sv
// Self-checking bench for win5x5_gen on an 8x6 image; an image-array model
// predicts every window, with literal anchors on the first and last windows.
module tb_win5x5_gen;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  win5x5_if #(.DATA_W(8)) bus ();
  win5x5_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] dut_x [25];
  assign dut_x[0]  = bus.x_0;  assign dut_x[1]  = bus.x_1;  assign dut_x[2]  = bus.x_2;
  assign dut_x[3]  = bus.x_3;  assign dut_x[4]  = bus.x_4;  assign dut_x[5]  = bus.x_5;
  assign dut_x[6]  = bus.x_6;  assign dut_x[7]  = bus.x_7;  assign dut_x[8]  = bus.x_8;
  assign dut_x[9]  = bus.x_9;  assign dut_x[10] = bus.x_10; assign dut_x[11] = bus.x_11;
  assign dut_x[12] = bus.x_12; assign dut_x[13] = bus.x_13; assign dut_x[14] = bus.x_14;
  assign dut_x[15] = bus.x_15; assign dut_x[16] = bus.x_16; assign dut_x[17] = bus.x_17;
  assign dut_x[18] = bus.x_18; assign dut_x[19] = bus.x_19; assign dut_x[20] = bus.x_20;
  assign dut_x[21] = bus.x_21; assign dut_x[22] = bus.x_22; assign dut_x[23] = bus.x_23;
  assign dut_x[24] = bus.x_24;

  int errors = 0;
  int checks = 0;
  int npulse = 0;

  // Model: the image as written so far plus the frame position of the next pixel.
  int img [H][W];
  int mrow, mcol;
  int exp_win [25];
  bit exp_valid, exp_eof, exp_known;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mrow = 0; mcol = 0;
    exp_valid = 1'b0; exp_eof = 1'b0; exp_known = 1'b1;
    for (int i = 0; i < 25; i++) exp_win[i] = 0;
  endtask

  // Taps after an accept are the 5x5 block ending at that pixel; only
  // blocks fully inside the current frame are predicted and qualified.
  task automatic model_acc(input bit v, input logic [7:0] p, input bit s);
    exp_valid = 1'b0;
    exp_eof   = 1'b0;
    if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = int'(p);
      if (mrow >= 4 && mcol >= 4) begin
        exp_valid = 1'b1;
        exp_known = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) exp_win[5*i+j] = img[mrow-4+i][mcol-4+j];
      end else begin
        exp_known = 1'b0;
      end
      exp_eof = (mrow == H-1) && (mcol == W-1);
      if (mcol == W-1) begin
        mcol = 0;
        mrow = (mrow == H-1) ? 0 : mrow + 1;
      end else begin
        mcol = mcol + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int bad;
      chk("win_valid", 32'(bus.win_valid), 32'(exp_valid));
      chk("eof", 32'(bus.eof), 32'(exp_eof));
      if (exp_known) begin
        bad = -1;
        for (int i = 0; i < 25; i++)
          if (bad < 0 && dut_x[i] !== 8'(exp_win[i])) bad = i;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL taps x_%0d: got %0h want %0h at %0t", bad, dut_x[bad], exp_win[bad], $time);
        end
      end
      if (bus.win_valid === 1'b1) npulse++;
    end
  end

  task automatic step(input bit v, input logic [7:0] p, input bit s);
    bus.in_valid = v;
    bus.in_pix   = p;
`ifdef WIN_SOF_EN
    bus.sof      = s;
`endif
    @(posedge clk);
    model_acc(v, p, s);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // One full frame of base+row*16+col; optional idle gap after each pixel.
  task automatic frame(input logic [7:0] base, input bit gaps, input bit sof_first);
    int p0;
    p0 = npulse;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, base + 8'(r*16 + c), sof_first && r == 0 && c == 0);
        if (r == 4 && c == 4) begin
          chk("first_x0",  32'(dut_x[0]),  32'(base));
          chk("first_x4",  32'(dut_x[4]),  32'(base + 8'h04));
          chk("first_x12", 32'(dut_x[12]), 32'(base + 8'h22));
          chk("first_x20", 32'(dut_x[20]), 32'(base + 8'h40));
          chk("first_x24", 32'(dut_x[24]), 32'(base + 8'h44));
          chk("model_x12", 32'(exp_win[12]), 32'(base + 8'h22));
        end
        if (r == H-1 && c == W-1) begin
          chk("last_eof",   32'(bus.eof), 32'd1);
          chk("last_valid", 32'(bus.win_valid), 32'd1);
          chk("last_x24",   32'(dut_x[24]), 32'(base + 8'h57));
        end
        if (gaps) step(1'b0, 8'hEE, 1'b0);
      end
    end
    step(1'b0, 8'h00, 1'b0);
    chk("pulse_count", 32'(npulse - p0), 32'd8);
  endtask

  initial begin
    int p0;
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
`ifdef WIN_SOF_EN
    bus.sof      = 1'b0;
`endif
    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("rst_valid", 32'(bus.win_valid), 32'd0);
    chk("rst_eof",   32'(bus.eof), 32'd0);
    chk("rst_x12",   32'(dut_x[12]), 32'd0);

    frame(8'h00, 1'b0, 1'b0);
    frame(8'h00, 1'b0, 1'b0);
    frame(8'h00, 1'b1, 1'b0);

    // Partial frame up to pixel (3,2), reset, then a fresh frame.
    p0 = npulse;
    for (int i = 0; i <= 3*W + 2; i++) step(1'b1, 8'((i / W) * 16 + (i % W)), 1'b0);
    do_reset();
    chk("mid_rst_valid", 32'(bus.win_valid), 32'd0);
    chk("mid_rst_pulses", 32'(npulse - p0), 32'd0);
    frame(8'h80, 1'b0, 1'b0);

`ifdef WIN_SOF_EN
    // Truncate a frame at pixel index 20; sof without in_valid is ignored.
    p0 = npulse;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'((i / W) * 16 + (i % W)), 1'b0);
      if (i == 10) step(1'b0, 8'h00, 1'b1);
    end
    chk("sof_no_pulses", 32'(npulse - p0), 32'd0);
    frame(8'h80, 1'b0, 1'b1);
`endif

    repeat (3) step(1'b0, 8'h00, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/win5x5_gen.md
Name: win5x5_gen

Overview:
Streaming 5x5 window generator for the median filter path. Accepts a raster-order pixel stream, one pixel per clock when valid. Uses four line buffers plus a 5x5 register array to present a full neighbourhood on x_0..x_24 with a qualifying valid flag. It sits directly upstream of sort_pipe, which consumes x_0..x_24 and produces median.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 640, pixels per line (>=5)
IMG_H, 480, lines per frame (>=5)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  pixel qualifier; pixel accepted on posedge when high
in_pix  in  DATA_W  pixel data, raster order
x_0 .. x_24  out  DATA_W each  window taps, x_(5*r+c)
win_valid  out  1  x_0..x_24 hold a complete in-frame 5x5 window
eof  out  1  one-cycle pulse: last pixel of frame accepted
sof  in  1  frame start marker (only with WIN_SOF_EN)

Behaviour:
- Single clock domain (clk); reset synchronous, active-high (rst); no other reset.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1, width $clog2 of bound. Advance only on accepted pixel. col wraps to 0 at IMG_W-1 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0.
- Line buffers LB0..LB3, IMG_W x DATA_W each, addressed by col. On accept: LB0[col]<=in_pix, LBk[col]<=old LB(k-1)[col]. Read-before-write at same address. Buffer RAM is not reset.
- Window shift on accept only. Each row shifts left one column; newest column enters at c=4: r=4 gets in_pix, r=3 gets LB0[col], r=2 LB1[col], r=1 LB2[col], r=0 LB3[col].
- Tap mapping: r=0 is the oldest line (row-4), c=0 the oldest column (col-4). x_24 = newest pixel, x_12 = centre (row-2, col-2), x_0 = (row-4, col-4).
- Latency: taps and win_valid are registered and update 1 cycle after the accepting edge.
- win_valid <= accept && row>=4 && col>=4, evaluated with pre-increment counters. The column gate keeps a window from spanning lines. Valid windows per frame = (IMG_W-4)*(IMG_H-4).
- in_valid low: counters, taps and line buffers hold; win_valid<=0; eof<=0.
- eof <= accept at (IMG_H-1, IMG_W-1). It is coincident with the frame's last win_valid.
- No backpressure. Downstream sort_pipe is fully pipelined and always accepts.
- Reset: col=0, row=0, all x_i=0, win_valid=0, eof=0. Reset mid-frame discards the partial frame. The first win_valid after reset comes only after 4 full new lines plus 5 pixels, because stale line buffer data is never qualified.
- Frame boundary: row returns to 0, so no window mixing two frames is ever qualified.

Optional Feature:
WIN_SOF_EN. When defined, port sof exists. sof=1 with in_valid=1 forces the pixel to be treated as (0,0): col and row restart and win_valid is suppressed until row>=4 again. An early sof truncates the current frame without asserting eof. sof with in_valid=0 is ignored. When undefined, there is no sof port and framing relies solely on counters and rst.

Test Plan:
- IMG_W=8, IMG_H=6, DATA_W=8, continuous in_valid, in_pix=row*16+col -> first win_valid one cycle after pixel (4,4) is accepted, with x_0=0x00, x_4=0x04, x_12=0x22, x_20=0x40, x_24=0x44.
- Same frame -> exactly 8 win_valid pulses, at pixels (4,4..7) and (5,4..7). eof is a single pulse coincident with window x_24=0x57. The second frame repeats identical windows.
- Same stream with in_valid low every other cycle -> the identical 8 windows in the same order. Taps are stable and win_valid=0 during gaps; no pulse lands on an idle cycle.
- rst for 1 cycle after pixel (3,2) of frame, then restart from (0,0) with in_pix=0x80+row*16+col -> no win_valid until new pixel (4,4). First window has x_0=0x80 and x_24=0xC4, with no pre-reset data present.
- Wire to sort_pipe with a frame of all 9 except centre (2,2)=200 -> median=9 for every window that includes (2,2). Median output appears win5x5_gen latency (1) plus sort_pipe latency after the accepting edge.
- WIN_SOF_EN: assert sof at pixel index 20 of frame 1 -> counters restart at (0,0). No eof for frame 1; the next win_valid comes after 4 lines plus 5 pixels beyond sof.
